// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
//   Shared definitions for the data-memory arbiter: the arbitration state
//   encoding and the width of the burst and starvation counters.
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

  // Width of the burst and starvation counters; wide enough for limits up to 15
  localparam int CNT_W = 4;

  // IDLE: normal arbitration, LOCK: master 1 owns a burst,
  // COOL: one cycle where master 0 gets absolute priority after a burst
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOCK = 2'd1,
    COOL = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
//   Bundles the two requester ports, the memory-side port and the status
//   outputs of the data-memory arbiter.
//   Ports (signals):
//     m0_*      core load/store requester (req, we, addr, wdata / ack, rdata)
//     m1_*      loader/DMA requester, plus m1_lock for burst ownership
//     mem_*     single-port memory (addr, wdata, we / rdata)
//     stall_cpu core stall, addr_err out-of-range indication
//   Modports:
//     slave   the arbiter's view
//     master  the view of whatever drives requests and models the memory
// -----------------------------------------------------------------------------
interface dmem_arbiter_if;

  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_ack;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic        m1_we;
  logic        m1_lock;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_ack;
  logic [31:0] m1_rdata;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  logic        stall_cpu;
  logic        addr_err;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output mem_addr, mem_wdata, mem_we,
    output stall_cpu, addr_err
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  mem_addr, mem_wdata, mem_we,
    input  stall_cpu, addr_err
  );

endinterface

// File: rtl/dmem_arb_fsm.sv
// -----------------------------------------------------------------------------
// dmem_arb_fsm
//   Arbitration state machine for the data-memory arbiter. Holds the state,
//   the burst beat counter and the master-1 starvation counter, and decides
//   combinationally which master owns the memory this cycle.
//   Ports:
//     clk, rst          clock and synchronous active-high reset
//     m0_req            master 0 request
//     m1_req, m1_lock   master 1 request and burst-lock request
//     grant_m0/grant_m1 one-hot (or zero) grant for the current cycle
// -----------------------------------------------------------------------------
module dmem_arb_fsm
  import dmem_arb_pkg::*;
#(
  parameter int MAX_BURST    = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic m0_req,
  input  logic m1_req,
  input  logic m1_lock,
  output logic grant_m0,
  output logic grant_m1
);

  localparam logic [CNT_W-1:0] BURST_MAX  = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [CNT_W-1:0] burst_next;
  logic             lock_beat;

  // Grant decision. A locked beat in LOCK beats everything; COOL favours
  // master 0 unconditionally; otherwise a starved master 1 wins once, then
  // master 0 has priority. Reset forces no grant so nothing gets written.
  always_comb begin
    grant_m0  = 1'b0;
    grant_m1  = 1'b0;
    lock_beat = (state_q == LOCK) && m1_req && m1_lock;
    if (!rst) begin
      if (lock_beat) begin
        grant_m1 = 1'b1;
      end else if (state_q == COOL) begin
        if (m0_req)      grant_m0 = 1'b1;
        else if (m1_req) grant_m1 = 1'b1;
      end else if (m1_req && (starve_cnt_q == STARVE_MAX)) begin
        grant_m1 = 1'b1;
      end else if (m0_req) begin
        grant_m0 = 1'b1;
      end else if (m1_req) begin
        grant_m1 = 1'b1;
      end
    end
  end

  // Next-state and counter updates. burst_cnt counts granted beats of the
  // current burst including the one that entered LOCK; leaving LOCK for any
  // reason passes through COOL. The starvation counter is frozen while a
  // burst is in progress.
  always_comb begin
    state_d      = state_q;
    burst_cnt_d  = burst_cnt_q;
    starve_cnt_d = starve_cnt_q;
    burst_next   = burst_cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (grant_m1 && m1_lock && (MAX_BURST > 1)) begin
          state_d     = LOCK;
          burst_cnt_d = CNT_W'(1);
        end
      end
      LOCK: begin
        if (lock_beat && (burst_next != BURST_MAX)) begin
          burst_cnt_d = burst_next;
        end else begin
          state_d     = COOL;
          burst_cnt_d = '0;
        end
      end
      COOL: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        burst_cnt_d = '0;
      end
    endcase

    if (state_q != LOCK) begin
      if (m1_req && !grant_m1) begin
        starve_cnt_d = (starve_cnt_q == STARVE_MAX) ? starve_cnt_q
                                                    : starve_cnt_q + CNT_W'(1);
      end else begin
        starve_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      burst_cnt_q  <= '0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Two-requester arbiter in front of a single-port 32-bit data memory with a
//   combinational read and a falling-edge write. Each cycle one owner is
//   chosen; its address/data/write-enable drive the memory and it receives a
//   same-cycle ack and read data.
//   Ports:
//     CLK, RST  clock and synchronous active-high reset
//     bus       dmem_arbiter_if.slave: both requesters, memory port,
//               stall_cpu (master 0 waiting) and addr_err (granted access
//               beyond DEPTH-1)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int DEPTH        = 8,
  parameter int MAX_BURST    = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic           CLK,
  input  logic           RST,
  dmem_arbiter_if.slave  bus
);

  localparam logic [31:0] LAST_ADDR = 32'(DEPTH - 1);

  logic        grant_m0;
  logic        grant_m1;
  logic        granted;
  logic        sel_we;
  logic        addr_err;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [31:0] rdata_ok;

  dmem_arb_fsm #(
    .MAX_BURST    (MAX_BURST),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_fsm (
    .clk      (CLK),
    .rst      (RST),
    .m0_req   (bus.m0_req),
    .m1_req   (bus.m1_req),
    .m1_lock  (bus.m1_lock),
    .grant_m0 (grant_m0),
    .grant_m1 (grant_m1)
  );

  // Memory-side mux. With no grant the bus idles on master 0's fields so the
  // address lines do not toggle needlessly. An out-of-range access is still
  // acknowledged but neither writes nor returns data.
  always_comb begin
    sel_addr  = bus.m0_addr;
    sel_wdata = bus.m0_wdata;
    sel_we    = 1'b0;
    if (grant_m1) begin
      sel_addr  = bus.m1_addr;
      sel_wdata = bus.m1_wdata;
      sel_we    = bus.m1_we;
    end else if (grant_m0) begin
      sel_we    = bus.m0_we;
    end
    granted  = grant_m0 | grant_m1;
    addr_err = granted && (sel_addr > LAST_ADDR);
    rdata_ok = addr_err ? 32'h0 : bus.mem_rdata;
  end

  assign bus.mem_addr  = sel_addr;
  assign bus.mem_wdata = sel_wdata;
  assign bus.mem_we    = sel_we & ~addr_err;
  assign bus.addr_err  = addr_err;

  assign bus.m0_ack    = grant_m0;
  assign bus.m1_ack    = grant_m1;
  assign bus.m0_rdata  = grant_m0 ? rdata_ok : 32'h0;
  assign bus.m1_rdata  = grant_m1 ? rdata_ok : 32'h0;
  assign bus.stall_cpu = bus.m0_req & ~grant_m0;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter for the single-port data memory (32-bit word, combinational read, write committed on the memory's falling clock edge).
- Master 0 is the core load/store path; master 1 is the loader/DMA port with optional locked bursts.
- Per cycle, the block picks one owner, muxes that owner's address/data/write-enable to the memory, and returns read data with a same-cycle ack.
- It raises a stall to the core when master 0 loses arbitration, and bounds master-1 starvation and burst length.

Parameters:
- DEPTH, 8, number of memory words; an address is legal when addr <= DEPTH-1.
- MAX_BURST, 4, maximum consecutive granted beats for a locked master-1 burst (range 1..15).
- STARVE_LIMIT, 3, consecutive denied master-1 cycles after which master 1 beats master 0 once (range 1..15).

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- m0_req  in  1  master 0 access request.
- m0_we  in  1  master 0 write (1) / read (0).
- m0_addr  in  32  master 0 address.
- m0_wdata  in  32  master 0 write data.
- m0_ack  out  1  master 0 granted this cycle.
- m0_rdata  out  32  read data to master 0.
- m1_req  in  1  master 1 access request.
- m1_we  in  1  master 1 write / read.
- m1_lock  in  1  master 1 requests burst ownership.
- m1_addr  in  32  master 1 address.
- m1_wdata  in  32  master 1 write data.
- m1_ack  out  1  master 1 granted this cycle.
- m1_rdata  out  32  read data to master 1.
- mem_addr  out  32  address to memory.
- mem_wdata  out  32  write data to memory.
- mem_we  out  1  memory write enable.
- mem_rdata  in  32  memory read data.
- stall_cpu  out  1  equals m0_req & ~m0_ack.
- addr_err  out  1  granted access is out of range (current cycle).

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high (ports CLK, RST).
  - While RST=1: m0_ack=m1_ack=0, mem_we=0, addr_err=0, stall_cpu=m0_req.
  - At the reset edge: state<=IDLE, burst_cnt<=0, starve_cnt<=0. Reset mid-burst abandons the burst with no further writes.
- Timing:
  - Grant is combinational from the requests plus registered state. The ack, rdata and mem_* outputs all settle in the same cycle, so latency is 0 cycles.
  - Masters must drive request/address/data from posedge registers so mem_* is stable before the memory's falling-edge write.
- States: IDLE, LOCK, COOL (2-bit).
- IDLE:
  - If m1_req and starve_cnt==STARVE_LIMIT, grant M1. Otherwise, if m0_req, grant M0. Otherwise, if m1_req, grant M1. Otherwise, no grant.
  - If M1 is granted with m1_lock=1 and MAX_BURST>1, go to LOCK with burst_cnt<=1.
- LOCK:
  - M1 wins whenever m1_req & m1_lock, even over m0_req; burst_cnt increments per granted beat.
  - Exit to COOL when burst_cnt reaches MAX_BURST on a granted beat, or when m1_lock=0 or m1_req=0 (that cycle is arbitrated as in IDLE).
- COOL:
  - Lasts one cycle; M0 has absolute priority and M1 is granted only if m0_req=0.
  - Next state is IDLE. A locked M1 must re-win from IDLE.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, each cycle m1_req & ~m1_ack.
  - Clears on m1_ack or when m1_req=0.
  - Is not changed in LOCK.
- Datapath:
  - mem_addr/mem_wdata come from the granted master, defaulting to M0's fields when there is no grant.
  - mem_we = granted we & ~addr_err.
  - Both rdata outputs carry mem_rdata when granted and no error; otherwise 0.
- Range check:
  - An address > DEPTH-1 still acks and sets addr_err.
  - The write is suppressed and rdata=0; no state penalty.
- m0_ack and m1_ack are never both 1.

Decomposition:
- Package dmem_arb_pkg holds the state encoding (IDLE=0, LOCK=1, COOL=2) and the counter width constant CNT_W=4.
- One natural sub-module, dmem_arb_fsm: the state, burst_cnt and starve_cnt registers plus the grant decision.
- The top level holds the mux, range check and outputs.

Test Plan:
- Single master: m0 write addr 2 data 0xA5A5_0001, then read -> m0_ack=1 both cycles, mem_we=1 first cycle, m0_rdata=0xA5A5_0001, stall_cpu=0.
- Contention: m0_req and m1_req held high, no lock -> M0 acks cycles 1-3 with stall_cpu=0; M1 acks cycle 4 (starve_cnt hit 3); M0 acks again cycle 5.
- Locked burst: m1_lock=1, m1 writes addr 0..5, m0_req high throughout -> M1 acks 4 consecutive beats (LOCK), then COOL grants M0 one cycle; stall_cpu=1 during the burst.
- Out of range: m0 write addr 8 data 0xDEAD_BEEF -> m0_ack=1, addr_err=1, mem_we=0; a later read of addr 0 shows it unchanged.
- Reset mid-burst: RST=1 on the 2nd locked beat -> acks 0 and mem_we 0 that cycle; next cycle state IDLE and counters 0, and M0 wins the next contention.
